// File: rtl/pcie_rp_pkg.sv
// Shared constants and types for the RootPort requester-request path.
package pcie_rp_pkg;

  // Request types understood by the scheduler; anything else is unsupported.
  localparam logic [3:0] REQ_NONE   = 4'b0000;
  localparam logic [3:0] REQ_CFGRD1 = 4'b1000;

  // Response status encodings returned alongside rsp_valid.
  localparam logic [1:0] RSP_OK       = 2'd0;
  localparam logic [1:0] RSP_TIMEOUT  = 2'd1;
  localparam logic [1:0] RSP_UNSUP    = 2'd2;
  localparam logic [1:0] RSP_LINKDOWN = 2'd3;

  // Bit positions inside the encoder status word.
  localparam int ENC_ST_BUSY = 0;
  localparam int ENC_ST_DONE = 1;

  // Scheduler state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // One requester's request fields.
  typedef struct packed {
    logic [3:0]  req_type;
    logic [15:0] completer_id;
    logic [9:0]  reg_number;
    logic [10:0] dword_count;
  } cfg_req_t;

endpackage

// File: rtl/pcie_cfg_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// wrapping around to index 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Wrapped candidates (below ptr) first, then those at/after ptr override them;
  // descending scans make the lowest index of each group win.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        grant       = '0;
        grant[i]    = 1'b1;
        grant_idx   = IW'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        grant       = '0;
        grant[i]    = 1'b1;
        grant_idx   = IW'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_cfg_req_scheduler.sv
// Shares the CfgRd1 path of the TLP encoder among NUM_REQ requesters: round-robin
// grant, one-cycle command, wait for done/timeout/link-down, per-requester response.
module pcie_cfg_req_scheduler
  import pcie_rp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_type,
  input  logic [16*NUM_REQ-1:0]   req_completer_id,
  input  logic [10*NUM_REQ-1:0]   req_reg_number,
  input  logic [11*NUM_REQ-1:0]   req_dword_count,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [3:0]              enc_req_type,
  output logic [15:0]             enc_completer_id,
  output logic [9:0]              enc_reg_number,
  output logic [10:0]             enc_dword_count,
  input  logic [31:0]             enc_status,
  output logic                    sched_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e       state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   lat_idx, lat_idx_d;
  logic [TIMER_W-1:0] timer, timer_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  cfg_req_t           req_fields [NUM_REQ];
  cfg_req_t           sel;
  logic [NUM_REQ-1:0] lat_onehot;
  logic               wait_exit;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [1:0]         rsp_status_d;
  logic [3:0]         enc_req_type_d;
  logic [15:0]        enc_completer_id_d;
  logic [9:0]         enc_reg_number_d;
  logic [10:0]        enc_dword_count_d;
  logic               sched_busy_d;

  // Only the busy and done bits of the encoder status carry meaning here.
  logic unused_enc_status_bits;
  assign unused_enc_status_bits = ^enc_status[31:2];

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Unpack the flat request buses into one struct per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_fields[i].req_type     = req_type[4*i +: 4];
      req_fields[i].completer_id = req_completer_id[16*i +: 16];
      req_fields[i].reg_number   = req_reg_number[10*i +: 10];
      req_fields[i].dword_count  = req_dword_count[11*i +: 11];
    end
  end

  assign sel = req_fields[grant_idx];

  // One-hot form of the latched winner, used for the response pulse.
  always_comb begin
    lat_onehot          = '0;
    lat_onehot[lat_idx] = 1'b1;
  end

  // Next-state and next-output logic; the enc_* registers double as the latch
  // for the winner's fields, so the encoder sees stable values throughout WAIT.
  always_comb begin
    state_d            = state;
    rr_ptr_d           = rr_ptr;
    lat_idx_d          = lat_idx;
    timer_d            = timer;
    wait_exit          = 1'b0;
    req_ready_d        = '0;
    rsp_valid_d        = '0;
    rsp_status_d       = RSP_OK;
    enc_req_type_d     = REQ_NONE;
    enc_completer_id_d = enc_completer_id;
    enc_reg_number_d   = enc_reg_number;
    enc_dword_count_d  = enc_dword_count;

    case (state)
      ST_IDLE: begin
        if (user_lnk_up && grant_valid && !enc_status[ENC_ST_BUSY]) begin
          lat_idx_d   = grant_idx;
          req_ready_d = grant;
          if (sel.req_type == REQ_CFGRD1) begin
            state_d            = ST_ISSUE;
            enc_req_type_d     = sel.req_type;
            enc_completer_id_d = sel.completer_id;
            enc_reg_number_d   = sel.reg_number;
            enc_dword_count_d  = sel.dword_count;
            timer_d            = TIMER_W'(TIMEOUT_CYCLES);
          end else begin
            state_d      = ST_RESP;
            rsp_valid_d  = grant;
            rsp_status_d = RSP_UNSUP;
          end
        end
      end
      ST_ISSUE: begin
        // The command cycle counts as the first cycle of the timeout window.
        timer_d = timer - TIMER_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer - TIMER_W'(1);
        if (!user_lnk_up) begin
          wait_exit    = 1'b1;
          rsp_status_d = RSP_LINKDOWN;
        end else if (enc_status[ENC_ST_DONE]) begin
          wait_exit    = 1'b1;
          rsp_status_d = RSP_OK;
        end else if (timer == TIMER_W'(1)) begin
          wait_exit    = 1'b1;
          rsp_status_d = RSP_TIMEOUT;
        end
        if (wait_exit) begin
          state_d            = ST_RESP;
          rsp_valid_d        = lat_onehot;
          enc_completer_id_d = '0;
          enc_reg_number_d   = '0;
          enc_dword_count_d  = '0;
        end else begin
          rsp_status_d = RSP_OK;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    sched_busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      lat_idx          <= '0;
      timer            <= '0;
      req_ready        <= '0;
      rsp_valid        <= '0;
      rsp_status       <= RSP_OK;
      enc_req_type     <= REQ_NONE;
      enc_completer_id <= '0;
      enc_reg_number   <= '0;
      enc_dword_count  <= '0;
      sched_busy       <= 1'b0;
    end else begin
      state            <= state_d;
      rr_ptr           <= rr_ptr_d;
      lat_idx          <= lat_idx_d;
      timer            <= timer_d;
      req_ready        <= req_ready_d;
      rsp_valid        <= rsp_valid_d;
      rsp_status       <= rsp_status_d;
      enc_req_type     <= enc_req_type_d;
      enc_completer_id <= enc_completer_id_d;
      enc_reg_number   <= enc_reg_number_d;
      enc_dword_count  <= enc_dword_count_d;
      sched_busy       <= sched_busy_d;
    end
  end

endmodule

// File: tb/tb_pcie_cfg_req_scheduler.sv
// Directed bench for pcie_cfg_req_scheduler with a response scoreboard.
module tb_pcie_cfg_req_scheduler;
  import pcie_rp_pkg::*;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic                  user_clk = 1'b0;
  logic                  user_reset;
  logic                  user_lnk_up;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_type;
  logic [16*NUM_REQ-1:0] req_completer_id;
  logic [10*NUM_REQ-1:0] req_reg_number;
  logic [11*NUM_REQ-1:0] req_dword_count;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [1:0]            rsp_status;
  logic [3:0]            enc_req_type;
  logic [15:0]           enc_completer_id;
  logic [9:0]            enc_reg_number;
  logic [10:0]           enc_dword_count;
  logic [31:0]           enc_status;
  logic                  sched_busy;

  typedef struct {
    int         idx;
    logic [1:0] status;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   rsp_seen     = 0;
  int   enc_cmds     = 0;
  int   n_pushed     = 0;

  always #5 user_clk = ~user_clk;

  pcie_cfg_req_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .user_lnk_up      (user_lnk_up),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_type         (req_type),
    .req_completer_id (req_completer_id),
    .req_reg_number   (req_reg_number),
    .req_dword_count  (req_dword_count),
    .rsp_valid        (rsp_valid),
    .rsp_status       (rsp_status),
    .enc_req_type     (enc_req_type),
    .enc_completer_id (enc_completer_id),
    .enc_reg_number   (enc_reg_number),
    .enc_dword_count  (enc_dword_count),
    .enc_status       (enc_status),
    .sched_busy       (sched_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [3:0] t, input logic [15:0] cid,
                               input logic [9:0] rn, input logic [10:0] dw);
    req_type[idx*4 +: 4]          = t;
    req_completer_id[idx*16 +: 16] = cid;
    req_reg_number[idx*10 +: 10]   = rn;
    req_dword_count[idx*11 +: 11]  = dw;
    req_valid[idx]                 = 1'b1;
  endtask

  task automatic pushExpected(input int idx, input logic [1:0] status);
    exp_t e;
    e.idx    = idx;
    e.status = status;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry;
  // also count cycles on which a command reaches the encoder.
  always @(negedge user_clk) begin
    if (enc_req_type != REQ_NONE) enc_cmds++;
    if (rsp_valid != '0) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.idx));
        checkOutput("sb_rsp_status", 32'(rsp_status), 32'(mon_e.status));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    int         w;
    int         cmds0;
    logic [3:0] acc;

    user_reset       = 1'b1;
    user_lnk_up      = 1'b1;
    req_valid        = '0;
    req_type         = '0;
    req_completer_id = '0;
    req_reg_number   = '0;
    req_dword_count  = '0;
    enc_status       = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("rst_enc_req_type", 32'(enc_req_type), 32'd0);
    checkOutput("rst_enc_cid", 32'(enc_completer_id), 32'd0);
    checkOutput("rst_busy", 32'(sched_busy), 32'd0);
    user_reset = 1'b0;
    tick();

    // Round-robin: all requesters hold requests, encoder answers 2 cycles after ISSUE
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, REQ_CFGRD1, 16'h1000 + 16'(i), 10'h010 + 10'(i), 11'(i + 1));
    for (int g = 0; g < 5; g++) begin
      w = g % NUM_REQ;
      pushExpected(w, RSP_OK);
      n = 0;
      do begin
        tick();
        n++;
      end while (req_ready == '0 && n < 10);
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << w));
      checkOutput("rr_enc_type", 32'(enc_req_type), 32'(REQ_CFGRD1));
      checkOutput("rr_enc_cid", 32'(enc_completer_id), 32'(16'h1000 + 16'(w)));
      checkOutput("rr_enc_dw", 32'(enc_dword_count), 32'(w + 1));
      tick();
      tick();
      enc_status = 32'h2;
      tick();
      enc_status = 32'h0;
      checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(1 << w));
    end
    req_valid = '0;
    tick();

    // Single CfgRd1 from requester 2, done 5 cycles after ISSUE
    cmds0 = enc_cmds;
    applyStimulus(2, REQ_CFGRD1, 16'h0100, 10'h004, 11'd1);
    pushExpected(2, RSP_OK);
    tick();
    checkOutput("one_req_ready", 32'(req_ready), 32'h4);
    checkOutput("one_enc_type", 32'(enc_req_type), 32'h8);
    checkOutput("one_enc_reg", 32'(enc_reg_number), 32'h004);
    checkOutput("one_enc_cid", 32'(enc_completer_id), 32'h0100);
    checkOutput("one_busy", 32'(sched_busy), 32'd1);
    req_valid[2] = 1'b0;
    tick();
    checkOutput("one_wait_type", 32'(enc_req_type), 32'd0);
    checkOutput("one_wait_reg_hold", 32'(enc_reg_number), 32'h004);
    checkOutput("one_wait_ready", 32'(req_ready), 32'd0);
    repeat (4) tick();
    enc_status = 32'h2;
    tick();
    enc_status = 32'h0;
    checkOutput("one_rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("one_rsp_status", 32'(rsp_status), 32'(RSP_OK));
    tick();
    checkOutput("one_idle_busy", 32'(sched_busy), 32'd0);
    checkOutput("one_cmd_cycles", 32'(enc_cmds - cmds0), 32'd1);

    // Timeout: no done, response exactly TIMEOUT_CYCLES after the ISSUE cycle
    applyStimulus(3, REQ_CFGRD1, 16'h0200, 10'h008, 11'd1);
    pushExpected(3, RSP_TIMEOUT);
    tick();
    checkOutput("to_req_ready", 32'(req_ready), 32'h8);
    req_valid[3] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid == '0 && n < 20);
    checkOutput("to_latency", 32'(n), 32'(TIMEOUT_CYCLES));
    checkOutput("to_rsp_status", 32'(rsp_status), 32'(RSP_TIMEOUT));
    tick();

    // Done arriving on the last timeout cycle wins over timeout
    applyStimulus(0, REQ_CFGRD1, 16'h0300, 10'h00C, 11'd1);
    pushExpected(0, RSP_OK);
    tick();
    checkOutput("edge_req_ready", 32'(req_ready), 32'h1);
    req_valid[0] = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    enc_status = 32'h2;
    tick();
    enc_status = 32'h0;
    checkOutput("edge_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("edge_rsp_status", 32'(rsp_status), 32'(RSP_OK));
    tick();

    // Unsupported type from requester 1 never reaches the encoder
    cmds0 = enc_cmds;
    applyStimulus(1, 4'b0001, 16'h0400, 10'h010, 11'd1);
    pushExpected(1, RSP_UNSUP);
    tick();
    checkOutput("uns_req_ready", 32'(req_ready), 32'h2);
    checkOutput("uns_rsp_status", 32'(rsp_status), 32'(RSP_UNSUP));
    checkOutput("uns_enc_type", 32'(enc_req_type), 32'd0);
    req_valid[1] = 1'b0;
    tick();
    checkOutput("uns_no_cmd", 32'(enc_cmds - cmds0), 32'd0);

    // Link drop for one cycle during WAIT
    applyStimulus(2, REQ_CFGRD1, 16'h0500, 10'h014, 11'd1);
    pushExpected(2, RSP_LINKDOWN);
    tick();
    req_valid[2] = 1'b0;
    tick();
    user_lnk_up = 1'b0;
    tick();
    user_lnk_up = 1'b1;
    checkOutput("ld_rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("ld_rsp_status", 32'(rsp_status), 32'(RSP_LINKDOWN));
    tick();

    // Link low in IDLE: nothing accepted until the link returns
    user_lnk_up = 1'b0;
    applyStimulus(0, 4'b0100, 16'h0600, 10'h018, 11'd1);
    acc = '0;
    repeat (4) begin
      tick();
      acc = acc | req_ready;
    end
    checkOutput("ll_no_ready", 32'(acc), 32'd0);
    checkOutput("ll_idle_busy", 32'(sched_busy), 32'd0);
    pushExpected(0, RSP_UNSUP);
    user_lnk_up = 1'b1;
    tick();
    checkOutput("ll_ready_after_up", 32'(req_ready), 32'h1);
    req_valid[0] = 1'b0;
    tick();

    // Reset during WAIT: no response, outputs cleared, pointer back to 0
    applyStimulus(3, REQ_CFGRD1, 16'h0700, 10'h01C, 11'd1);
    tick();
    checkOutput("rw_req_ready", 32'(req_ready), 32'h8);
    req_valid[3] = 1'b0;
    tick();
    tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    checkOutput("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rw_enc_type", 32'(enc_req_type), 32'd0);
    checkOutput("rw_enc_cid", 32'(enc_completer_id), 32'd0);
    checkOutput("rw_busy", 32'(sched_busy), 32'd0);
    applyStimulus(0, REQ_CFGRD1, 16'h0800, 10'h020, 11'd1);
    applyStimulus(1, REQ_CFGRD1, 16'h0900, 10'h024, 11'd1);
    pushExpected(0, RSP_OK);
    tick();
    checkOutput("rw_next_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    enc_status = 32'h2;
    tick();
    enc_status = 32'h0;
    checkOutput("rw_rsp_valid2", 32'(rsp_valid), 32'h1);
    repeat (3) tick();

    // Every expected response must have been produced exactly once
    checkOutput("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("sb_rsp_count", 32'(rsp_seen), 32'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
